// File: rtl/instr_inv_queue_if.sv
// rtl/instr_inv_queue_if.sv - request, icache and branch-predictor invalidation ports of instr_inv_queue
interface instr_inv_queue_if #(
   parameter int ADDR_W = 28
);
   logic              inv_valid;
   logic [31:0]       inv_addr;
   logic              inv_ready;
   logic              ic_inv_valid;
   logic [ADDR_W-1:0] ic_inv_addr;
   logic              ic_inv_ack;
   logic              bp_inv_valid;
   logic [ADDR_W-1:0] bp_inv_addr;
   logic              bp_inv_ack;
   logic              empty;

   modport master (
      output inv_valid, inv_addr, ic_inv_ack, bp_inv_ack,
      input  inv_ready, ic_inv_valid, ic_inv_addr, bp_inv_valid, bp_inv_addr, empty
   );

   modport slave (
      input  inv_valid, inv_addr, ic_inv_ack, bp_inv_ack,
      output inv_ready, ic_inv_valid, ic_inv_addr, bp_inv_valid, bp_inv_addr, empty
   );
endinterface

// File: rtl/instr_inv_queue.sv
// rtl/instr_inv_queue.sv - instruction-coherency invalidation FIFO feeding icache and branch predictor
// Optional tail merging of same-line requests under `INSTR_INV_COALESCE_EN.
module instr_inv_queue #(
   parameter int DEPTH         = 4,
   parameter int LINE_OFFSET_W = 4,
   parameter int ADDR_W        = 32 - LINE_OFFSET_W
) (
   input  logic              clk,
   input  logic              rst,
   instr_inv_queue_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ic_done_q, ic_done_d;
   logic              bp_done_q, bp_done_d;

   logic [ADDR_W-1:0] req_line;
   logic              is_empty;
   logic              ic_ack;
   logic              bp_ack;
   logic              accept;
   logic              merge;
   logic              push;
   logic              pop;
`ifdef INSTR_INV_COALESCE_EN
   logic [PTR_W-1:0]  tail_last;
`endif

   assign req_line = bus.inv_addr[31:LINE_OFFSET_W];

   always_comb begin
      is_empty = (count_q == '0);
      // Acks only count while the matching valid is being presented.
      ic_ack   = !is_empty && !ic_done_q && bus.ic_inv_ack;
      bp_ack   = !is_empty && !bp_done_q && bus.bp_inv_ack;
      accept   = bus.inv_valid && (count_q != DEPTH_C);
`ifdef INSTR_INV_COALESCE_EN
      tail_last = tail_q - PTR_W'(1);
      // A lone head entry already seen by either consumer must not absorb a new request.
      merge = accept && (count_q != '0) && (mem_q[tail_last] == req_line) &&
              ((count_q != CNT_W'(1)) ||
               (!ic_done_q && !bp_done_q && !ic_ack && !bp_ack));
`else
      merge = 1'b0;
`endif
      push = accept && !merge;
      pop  = !is_empty && (ic_done_q || ic_ack) && (bp_done_q || bp_ack);
   end

   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[tail_q] = req_line;
      end
      tail_d = push ? tail_q + PTR_W'(1) : tail_q;
      head_d = pop  ? head_q + PTR_W'(1) : head_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      ic_done_d = pop ? 1'b0 : (ic_done_q || ic_ack);
      bp_done_d = pop ? 1'b0 : (bp_done_q || bp_ack);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         ic_done_q <= 1'b0;
         bp_done_q <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         ic_done_q <= ic_done_d;
         bp_done_q <= bp_done_d;
      end
   end

   // Address outputs read zero whenever nothing is held, including straight out of reset.
   assign bus.inv_ready    = (count_q != DEPTH_C);
   assign bus.empty        = is_empty;
   assign bus.ic_inv_valid = !is_empty && !ic_done_q;
   assign bus.bp_inv_valid = !is_empty && !bp_done_q;
   assign bus.ic_inv_addr  = is_empty ? '0 : mem_q[head_q];
   assign bus.bp_inv_addr  = is_empty ? '0 : mem_q[head_q];
endmodule
